path_delay_emulator: RTL and testbench

//  Synthesizable, clocked counterpart of specify-block module path delays.

---
 rtl/path_delay_emulator.sv | 147 ++++++++++++++
 tb/tb_path_delay_emulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/path_delay_emulator.sv
// Clocked emulation of rise/fall path delays with inertial pulse rejection.
// Each channel runs a STABLE/PENDING countdown; rejected pulses feed a shared saturating counter.
module path_delay_emulator #(
    parameter int          CHANNELS = 4,
    parameter int          DELAY_W  = 8,
    parameter int          CNT_W    = 16,
    parameter int unsigned DEF_RISE = 1,
    parameter int unsigned DEF_FALL = 1,
    localparam int         CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_sig,
    output logic [CHANNELS-1:0] out_sig,
    output logic [CHANNELS-1:0] busy,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_sel,
    input  logic [DELAY_W-1:0]  cfg_wdata,
    output logic [DELAY_W-1:0]  cfg_rdata,
    input  logic                glitch_clr,
    output logic [CNT_W-1:0]    glitch_cnt
);
    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

    localparam int EV_W  = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_W + EV_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CHANNELS-1:0]              cancel_w;
    logic [CHANNELS-1:0][DELAY_W-1:0] rise_w;
    logic [CHANNELS-1:0][DELAY_W-1:0] fall_w;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : gen_ch
            logic [DELAY_W-1:0] rise_q, fall_q;
            logic [DELAY_W-1:0] cnt_q, cnt_d;
            logic [DELAY_W-1:0] load_val;
            state_t             state_q, state_d;
            logic               target_q, target_d;
            logic               out_q, out_d;
            logic               cancel;
            logic               wr_hit;

            assign wr_hit = cfg_we && (cfg_ch == CH_W'(gi));

            // Register writes never touch cnt_q, so a running countdown is unaffected.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise_q <= DELAY_W'(DEF_RISE);
                    fall_q <= DELAY_W'(DEF_FALL);
                end else if (wr_hit) begin
                    if (cfg_sel) fall_q <= cfg_wdata;
                    else         rise_q <= cfg_wdata;
                end
            end

            assign load_val = in_sig[gi] ? rise_q : fall_q;

            always_comb begin
                state_d  = state_q;
                target_d = target_q;
                cnt_d    = cnt_q;
                out_d    = out_q;
                cancel   = 1'b0;
                case (state_q)
                    STABLE: begin
                        if (in_sig[gi] != out_q) begin
                            target_d = in_sig[gi];
                            cnt_d    = load_val;
                            state_d  = PENDING;
                        end
                    end
                    PENDING: begin
                        if (cnt_q != '0) begin
                            if (in_sig[gi] == target_q) begin
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                state_d = STABLE;
                                cancel  = 1'b1;
                            end
                        end else begin
                            // Expiry: commit, then immediately chase a new input level if it moved.
                            out_d = target_q;
                            if (in_sig[gi] != target_q) begin
                                target_d = in_sig[gi];
                                cnt_d    = load_val;
                            end else begin
                                state_d = STABLE;
                            end
                        end
                    end
                    default: state_d = STABLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q  <= STABLE;
                    target_q <= 1'b0;
                    cnt_q    <= '0;
                    out_q    <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    target_q <= target_d;
                    cnt_q    <= cnt_d;
                    out_q    <= out_d;
                end
            end

            assign out_sig[gi]  = out_q;
            assign busy[gi]     = (state_q == PENDING);
            assign cancel_w[gi] = cancel;
            assign rise_w[gi]   = rise_q;
            assign fall_w[gi]   = fall_q;
        end
    endgenerate

    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_rdata = cfg_sel ? fall_w[i] : rise_w[i];
        end
    end

    logic [EV_W-1:0]  events;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] glitch_q, glitch_d;

    // Clear drops the old total but still keeps the cancellations of the same edge.
    always_comb begin
        events = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            events = events + EV_W'(cancel_w[i]);
        end
        sum      = (glitch_clr ? '0 : SUM_W'(glitch_q)) + SUM_W'(events);
        glitch_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_q <= '0;
        else        glitch_q <= glitch_d;
    end

    assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_path_delay_emulator.sv
// Scoreboard bench: each test queues per-cycle stimulus with its expected outputs, then drains it.
module tb_path_delay_emulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_sig;
    logic [3:0]  out_sig, busy;
    logic        cfg_we, cfg_sel, glitch_clr;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_wdata, cfg_rdata;
    logic [15:0] glitch_cnt;

    logic [2:0]  s_in, s_out, s_busy;
    logic        s_we, s_sel, s_clr;
    logic [1:0]  s_ch;
    logic [7:0]  s_wd, s_rd;
    logic [3:0]  s_gc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    path_delay_emulator u_dut (
        .clk(clk), .rst_n(rst_n), .in_sig(in_sig), .out_sig(out_sig), .busy(busy),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
    );

    path_delay_emulator #(.CHANNELS(3), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_sig(s_in), .out_sig(s_out), .busy(s_busy),
        .cfg_we(s_we), .cfg_ch(s_ch), .cfg_sel(s_sel), .cfg_wdata(s_wd),
        .cfg_rdata(s_rd), .glitch_clr(s_clr), .glitch_cnt(s_gc)
    );

    typedef struct {
        logic [3:0] in;
        logic       clr;
        logic [3:0] out;
        logic [3:0] bsy;
        int         gc;
        logic       we;
        logic [1:0] ch;
        logic       sel;
        logic [7:0] wd;
    } step_t;

    step_t sq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [3:0] i, input logic c, input logic [3:0] o,
                                 input logic [3:0] b, input int g, input logic we = 1'b0,
                                 input logic [1:0] ch = 2'd0, input logic sel = 1'b0,
                                 input logic [7:0] wd = 8'd0);
        step_t s;
        s.in = i; s.clr = c; s.out = o; s.bsy = b; s.gc = g;
        s.we = we; s.ch = ch; s.sel = sel; s.wd = wd;
        sq.push_back(s);
    endfunction

    function automatic void push_cfg(input logic [1:0] ch, input logic sel, input logic [7:0] wd);
        push(4'b0000, 1'b0, 4'b0000, 4'b0000, -1, 1'b1, ch, sel, wd);
    endfunction

    // Drives the oldest queued step for one clock and hands back what the DUT shows after it.
    task automatic apply(output step_t e, output logic [3:0] o, output logic [3:0] b,
                         output logic [15:0] g);
        e = sq.pop_front();
        in_sig = e.in; glitch_clr = e.clr;
        cfg_we = e.we; cfg_ch = e.ch; cfg_sel = e.sel; cfg_wdata = e.wd;
        tick();
        o = out_sig; b = busy; g = glitch_cnt;
        cfg_we = 1'b0; glitch_clr = 1'b0;
    endtask

    task automatic test_reset();
        if (out_sig !== 4'b0 || busy !== 4'b0 || glitch_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_init out=%b busy=%b gc=%0d want 0/0/0", out_sig, busy, glitch_cnt);
        end
        total++;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_wdata = 8'd7; in_sig = 4'b1111;
        tick();
        cfg_we = 1'b0;
        #1;
        total++;
        if (cfg_rdata !== 8'd7 || busy !== 4'b1111) begin
            bad++; $display("FAIL reset_pre rdata=%0d busy=%b want 7/1111", cfg_rdata, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_sig !== 4'b0 || busy !== 4'b0 || glitch_cnt !== 16'd0 || cfg_rdata !== 8'd1) begin
            bad++; $display("FAIL reset_async out=%b busy=%b gc=%0d rdata=%0d want 0/0/0/1",
                            out_sig, busy, glitch_cnt, cfg_rdata);
        end
        in_sig = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 2; s++) begin
                cfg_ch = 2'(c); cfg_sel = s[0];
                #1;
                total++;
                if (cfg_rdata !== 8'd1) begin
                    bad++; $display("FAIL reset_cfg ch%0d sel%0d got %0d want 1", c, s, cfg_rdata);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic drain(input string name);
        step_t e;
        logic [3:0] o, b;
        logic [15:0] g;
        int n = 0;
        while (sq.size() > 0) begin
            apply(e, o, b, g);
            total++;
            if (o !== e.out || b !== e.bsy || (e.gc >= 0 && g !== 16'(e.gc))) begin
                bad++;
                $display("FAIL %s step%0d out=%b busy=%b gc=%0d want out=%b busy=%b gc=%0d",
                         name, n, o, b, g, e.out, e.bsy, e.gc);
            end else begin
                $display("%s step%0d in=%b out=%b busy=%b gc=%0d ok", name, n, e.in, o, b, g);
            end
            n++;
        end
    endtask

    task automatic test_delays();
        push_cfg(2'd0, 1'b0, 8'd3);
        push_cfg(2'd0, 1'b1, 8'd5);
        for (int i = 0; i < 4; i++) push(4'b0001, 0, 4'b0000, 4'b0001, -1);
        push(4'b0001, 0, 4'b0001, 4'b0000, -1);
        push(4'b0001, 0, 4'b0001, 4'b0000, -1);
        for (int i = 0; i < 6; i++) push(4'b0000, 0, 4'b0001, 4'b0001, -1);
        push(4'b0000, 0, 4'b0000, 4'b0000, -1);
        drain("delays");
        cfg_ch = 2'd0; cfg_sel = 1'b0; #1;
        total++;
        if (cfg_rdata !== 8'd3) begin bad++; $display("FAIL delays_rd_rise got %0d want 3", cfg_rdata); end
        cfg_sel = 1'b1; #1;
        total++;
        if (cfg_rdata !== 8'd5) begin bad++; $display("FAIL delays_rd_fall got %0d want 5", cfg_rdata); end
    endtask

    task automatic test_inertial();
        push_cfg(2'd2, 1'b0, 8'd4);
        push(4'b0000, 1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 3; i++) push(4'b0100, 0, 4'b0000, 4'b0100, 0);
        push(4'b0000, 0, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 5; i++) push(4'b0100, 0, 4'b0000, 4'b0100, 1);
        push(4'b0000, 0, 4'b0100, 4'b0100, 1);
        push(4'b0000, 0, 4'b0100, 4'b0100, 1);
        push(4'b0000, 0, 4'b0000, 4'b0000, 1);
        drain("inertial");
    endtask

    task automatic test_zero_delay();
        push_cfg(2'd1, 1'b0, 8'd0);
        push_cfg(2'd1, 1'b1, 8'd0);
        push(4'b0010, 0, 4'b0000, 4'b0010, -1);
        push(4'b0000, 0, 4'b0010, 4'b0010, -1);
        push(4'b0000, 0, 4'b0000, 4'b0000, -1);
        push(4'b0000, 0, 4'b0000, 4'b0000, -1);
        drain("zero_delay");
    endtask

    task automatic test_aggregate();
        push_cfg(2'd1, 1'b0, 8'd2);
        push(4'b0000, 1, 4'b0000, 4'b0000, 0);
        push(4'b1111, 0, 4'b0000, 4'b1111, 0);
        push(4'b0000, 0, 4'b0000, 4'b0000, 4);
        push(4'b0011, 0, 4'b0000, 4'b0011, 4);
        push(4'b0000, 1, 4'b0000, 4'b0000, 2);
        drain("aggregate");
    endtask

    task automatic test_saturate();
        int exp_q[$];
        int exp_v = 0;
        int got;
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        total++;
        if (s_gc !== 4'd0) begin bad++; $display("FAIL sat_clear got %0d want 0", s_gc); end
        for (int p = 0; p < 6; p++) begin
            exp_v = (exp_v + 3 > 15) ? 15 : exp_v + 3;
            exp_q.push_back(exp_v);
            s_in = 3'b111; tick();
            s_in = 3'b000; tick();
            got = int'(s_gc);
            exp_v = exp_q.pop_front();
            total++;
            if (got != exp_v) begin
                bad++; $display("FAIL sat_pair%0d got %0d want %0d", p, got, exp_v);
            end else begin
                $display("saturate pair%0d gc=%0d ok", p, got);
            end
        end
        s_we = 1'b1; s_ch = 2'd3; s_sel = 1'b0; s_wd = 8'h55; tick();
        s_sel = 1'b1; tick();
        s_ch = 2'd2; s_sel = 1'b0; s_wd = 8'd9; tick();
        s_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 2; s++) begin
                logic [7:0] want;
                want = (c == 3) ? 8'd0 : ((c == 2 && s == 0) ? 8'd9 : 8'd1);
                s_ch = 2'(c); s_sel = s[0];
                #1;
                total++;
                if (s_rd !== want) begin
                    bad++; $display("FAIL sat_cfg ch%0d sel%0d got %0d want %0d", c, s, s_rd, want);
                end
            end
        end
    endtask

    task automatic test_config_race();
        push_cfg(2'd3, 1'b0, 8'd10);
        for (int i = 0; i < 11; i++) begin
            if (i == 3) push(4'b1000, 0, 4'b0000, 4'b1000, -1, 1'b1, 2'd3, 1'b0, 8'd2);
            else        push(4'b1000, 0, 4'b0000, 4'b1000, -1);
        end
        push(4'b1000, 0, 4'b1000, 4'b0000, -1);
        push(4'b0000, 0, 4'b1000, 4'b1000, -1);
        push(4'b0000, 0, 4'b1000, 4'b1000, -1);
        push(4'b0000, 0, 4'b0000, 4'b0000, -1);
        for (int i = 0; i < 3; i++) push(4'b1000, 0, 4'b0000, 4'b1000, -1);
        push(4'b1000, 0, 4'b1000, 4'b0000, -1);
        push(4'b0000, 0, 4'b1000, 4'b1000, -1);
        push(4'b0000, 0, 4'b1000, 4'b1000, -1);
        push(4'b0000, 0, 4'b0000, 4'b0000, -1);
        drain("config_race");
        cfg_ch = 2'd3; cfg_sel = 1'b0; #1;
        total++;
        if (cfg_rdata !== 8'd2) begin bad++; $display("FAIL race_rd got %0d want 2", cfg_rdata); end
    endtask

    initial begin
        rst_n = 1'b0; in_sig = '0; cfg_we = 0; cfg_ch = '0; cfg_sel = 0; cfg_wdata = '0; glitch_clr = 0;
        s_in = '0; s_we = 0; s_ch = '0; s_sel = 0; s_wd = '0; s_clr = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_delays();
        test_inertial();
        test_zero_delay();
        test_aggregate();
        test_saturate();
        test_config_race();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
